// File: rtl/priority_encoder_8to3_if.sv
// -----------------------------------------------------------------------------
// priority_encoder_8to3_if
//
// Purpose:
//   Bundles the request vector and the registered encoder results of
//   priority_encoder_8to3 so that producer and encoder share one port.
//
// Signals:
//   D     [7:0] request vector; bit 7 has the highest priority
//   Y     [2:0] registered index of the highest set bit of the sampled D
//   valid       registered; 1 when the sampled D had any bit set
//   multi       registered; 1 when the sampled D had two or more bits set
//
// Modports:
//   master - request source: drives D, observes Y/valid/multi
//   slave  - the encoder:    observes D, drives Y/valid/multi
// -----------------------------------------------------------------------------
interface priority_encoder_8to3_if;
    logic [7:0] D;
    logic [2:0] Y;
    logic       valid;
    logic       multi;

    modport master (
        output D,
        input  Y,
        input  valid,
        input  multi
    );

    modport slave (
        input  D,
        output Y,
        output valid,
        output multi
    );
endinterface

// File: rtl/priority_encoder_8to3.sv
// -----------------------------------------------------------------------------
// priority_encoder_8to3
//
// Purpose:
//   Registered 8-to-3 priority encoder. Every rising clock edge samples the
//   request vector and loads, one cycle later on the outputs:
//     Y     - index of the highest-numbered asserted request bit
//     valid - at least one request bit was asserted
//     multi - two or more request bits were asserted
//   With no request asserted Y is 000, so Y must always be qualified by valid.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset; clears Y/valid/multi immediately
//   bus  - priority_encoder_8to3_if.slave (D in; Y, valid, multi out)
// -----------------------------------------------------------------------------
module priority_encoder_8to3 (
    input  logic                          clk,
    input  logic                          rst,
    priority_encoder_8to3_if.slave        bus
);

    // -------------------------------------------------------------------------
    // Combinational next state
    // -------------------------------------------------------------------------
    logic [7:0] w_d;
    logic [7:0] w_above_clear;   // bit i: no request set above position i
    logic [7:0] w_winner;        // one-hot: the highest set request bit
    logic [2:0] w_next_y;
    logic       w_next_valid;
    logic       w_next_multi;

    assign w_d = bus.D;

    // A bit wins only when it is set and every higher-priority bit is clear.
    // Building the one-hot winner first keeps the index encode a plain OR.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_winner
            if (gi == 7) begin : g_top
                assign w_above_clear[gi] = 1'b1;
            end else begin : g_lower
                assign w_above_clear[gi] = ~|w_d[7:gi+1];
            end
            assign w_winner[gi] = w_d[gi] & w_above_clear[gi];
        end
    endgenerate

    // Encode the one-hot winner: each index bit is the OR of the winner
    // positions whose index has that bit set.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_encode
            logic [7:0] w_sel;
            for (genvar gj = 0; gj < 8; gj++) begin : g_sel
                assign w_sel[gj] = w_winner[gj] & (((gj >> gi) & 1) == 1);
            end
            assign w_next_y[gi] = |w_sel;
        end
    endgenerate

    assign w_next_valid = |w_d;

    // D & (D - 1) clears the lowest set bit; anything left over means at
    // least two bits were set. For D = 0 the subtraction wraps to all ones
    // and the AND is still zero, so multi stays low.
    assign w_next_multi = |(w_d & (w_d - 8'd1));

    // -------------------------------------------------------------------------
    // Output registers: the only state in the block. No enable, no hold.
    // -------------------------------------------------------------------------
    logic [2:0] r_y;
    logic       r_valid;
    logic       r_multi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y     <= 3'b000;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_y     <= w_next_y;
            r_valid <= w_next_valid;
            r_multi <= w_next_multi;
        end
    end

    assign bus.Y     = r_y;
    assign bus.valid = r_valid;
    assign bus.multi = r_multi;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder_8to3
//
// Drives request vectors on the falling edge, pushes the reference result
// into a scoreboard queue, and pops/compares one cycle later just after the
// rising edge that loads it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_priority_encoder_8to3;

    logic clk;
    logic rst;

    priority_encoder_8to3_if bus ();

    priority_encoder_8to3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] y;
        logic       valid;
        logic       multi;
    } exp_t;

    exp_t sb[$];
    int   total_cnt = 0;
    int   bad_cnt   = 0;

    // Reference: highest set index, OR-reduce, popcount > 1.
    function automatic exp_t ref_model(input logic [7:0] d);
        exp_t e;
        e.y = 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) e.y = 3'(i);
        end
        e.valid = (d != 8'h00);
        e.multi = ($countones(d) > 1);
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check_eq({tag, "_y"},     {5'd0, bus.Y},     {5'd0, e.y});
        check_eq({tag, "_valid"}, {7'd0, bus.valid}, {7'd0, e.valid});
        check_eq({tag, "_multi"}, {7'd0, bus.multi}, {7'd0, e.multi});
    endtask

    // Drive at the falling edge, then compare just after the next rising edge.
    task automatic drive_and_check(input string tag, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        bus.D = d;
        sb.push_back(ref_model(d));
        @(posedge clk);
        #1;
        check_eq({tag, "_sb_depth"}, 8'(sb.size()), 8'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_outputs(tag, e);
            $display("txn %s D=%08b Y=%03b valid=%0b multi=%0b", tag, d, bus.Y, bus.valid, bus.multi);
        end
    endtask

    exp_t zero_exp;
    exp_t held;

    initial begin
        zero_exp = '0;
        rst   = 1'b1;
        bus.D = 8'hFF;

        // Reset held with all requests set and the clock running.
        #1;
        check_outputs("rst_async_start", zero_exp);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_outputs("rst_hold_pos", zero_exp);
            @(negedge clk); #1;
            check_outputs("rst_hold_neg", zero_exp);
        end

        // Release away from the edge; first edge loads current D.
        @(negedge clk);
        rst = 1'b0;
        drive_and_check("release_ff", 8'hFF);

        // Single-bit sweep.
        drive_and_check("sweep_b0", 8'b00000001);
        drive_and_check("sweep_b2", 8'b00000100);
        drive_and_check("sweep_b5", 8'b00100000);
        drive_and_check("sweep_b6", 8'b01000000);
        drive_and_check("sweep_b7", 8'b10000000);

        // Zero versus bit 0.
        drive_and_check("zero", 8'b00000000);
        drive_and_check("bit0", 8'b00000001);

        // Multiple bits set.
        drive_and_check("multi_81", 8'b10000001);
        drive_and_check("multi_16", 8'b00010110);
        drive_and_check("multi_ff", 8'b11111111);

        // Several D changes between edges: only the value at the edge counts.
        held = ref_model(8'b11111111);
        @(negedge clk);
        bus.D = 8'b00000001;
        #1; check_outputs("glitch_mid1", held);
        bus.D = 8'b10000000;
        #1; check_outputs("glitch_mid2", held);
        bus.D = 8'b00001100;
        #1; check_outputs("glitch_mid3", held);
        sb.push_back(ref_model(8'b00001100));
        @(posedge clk); #1;
        check_eq("glitch_sb_depth", 8'(sb.size()), 8'd1);
        if (sb.size() > 0) check_outputs("glitch_edge", sb.pop_front());

        // Exhaustive sweep of every request vector.
        for (int v = 0; v < 256; v++) begin
            drive_and_check($sformatf("exh_%0d", v), 8'(v));
        end

        // Mid-cycle asynchronous reset with a result pending.
        drive_and_check("pre_async", 8'b11000000);
        @(negedge clk);
        bus.D = 8'hFF;
        sb.push_back(ref_model(8'hFF));
        #2;
        rst = 1'b1;
        sb.delete();             // pending result is discarded
        #1;
        check_outputs("async_rst_mid", zero_exp);
        @(posedge clk); #1;
        check_outputs("async_rst_edge", zero_exp);
        @(negedge clk);
        rst = 1'b0;
        drive_and_check("post_async", 8'b00100100);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    // Absolute safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
